// File: rtl/ix_pkg.sv
// Shared encodings for the execute stage: ALU op codes, branch conditions
// and the mult/div sequencer states.
package ix_pkg;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_AND   = 6'd2,
    OP_OR    = 6'd3,
    OP_XOR   = 6'd4,
    OP_NOR   = 6'd5,
    OP_SLT   = 6'd6,
    OP_SLTU  = 6'd7,
    OP_SLL   = 6'd8,
    OP_SRL   = 6'd9,
    OP_SRA   = 6'd10,
    OP_LUI   = 6'd11,
    OP_MULT  = 6'd12,
    OP_MULTU = 6'd13,
    OP_DIV   = 6'd14,
    OP_DIVU  = 6'd15,
    OP_MFHI  = 6'd16,
    OP_MFLO  = 6'd17,
    OP_MTHI  = 6'd18,
    OP_MTLO  = 6'd19
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_BEQ  = 2'd0,
    BR_BNE  = 2'd1,
    BR_BLEZ = 2'd2,
    BR_BGTZ = 2'd3
  } br_type_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_md_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_hilo_op(input logic [5:0] op);
    return is_md_op(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
           (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/ix_muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per
// clock on operand magnitudes, sign fix-up in the final cycle, HI/LO storage.
module ix_muldiv_unit
  import ix_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_div,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  md_state_e       state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc_hi, acc_lo, op_q, dividend;
  logic            neg_a, neg_b, div_op, b_zero;

  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN:0]   sum, r_shift;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] fix_hi, fix_lo;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg64_if(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign sa    = !is_unsigned && a[XLEN-1];
  assign sb    = !is_unsigned && b[XLEN-1];
  assign mag_a = neg_if(a, sa);
  assign mag_b = neg_if(b, sb);
  assign busy  = (state != MD_IDLE);

  // One iteration: multiply consumes the multiplier LSB-first from acc_lo,
  // divide shifts the dividend out of acc_lo into the partial remainder.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_q} : '0);
    r_shift = {acc_hi, acc_lo[XLEN-1]};
    diff    = {1'b0, r_shift} - {2'b00, op_q};
    if (div_op) begin
      if (!diff[XLEN+1]) begin
        step_hi = diff[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        step_hi = r_shift[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      {step_hi, step_lo} = {sum, acc_lo[XLEN-1:1]};
    end
  end

  always_comb begin
    if (div_op) begin
      if (b_zero) begin
        fix_lo = '1;
        fix_hi = dividend;
      end else begin
        fix_lo = neg_if(acc_lo, neg_a ^ neg_b);
        fix_hi = neg_if(acc_hi, neg_a);
      end
    end else begin
      {fix_hi, fix_lo} = neg64_if({acc_hi, acc_lo}, neg_a ^ neg_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_RUN;
            count <= CW'(MD_CYCLES);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MD_RUN: begin
          count <= count - 1'b1;
          if (count == CW'(1)) state <= MD_DONE;
        end
        MD_DONE: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded on issue.
  always_ff @(posedge clk) begin
    if (state == MD_IDLE && start) begin
      div_op   <= is_div;
      neg_a    <= sa;
      neg_b    <= sb;
      b_zero   <= (b == '0);
      dividend <= a;
      acc_hi   <= '0;
      acc_lo   <= is_div ? mag_a : mag_b;
      op_q     <= is_div ? mag_b : mag_a;
    end else if (state == MD_RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

endmodule

// File: rtl/ix_execute_stage.sv
// Execute stage: single-cycle ALU/shifter, branch and jump resolution, and the
// HI/LO interlock around the iterative mult/div unit.
module ix_execute_stage
  import ix_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubble_in,
  input  logic [31:0]     pc_in,
  input  logic [31:0]     ir_in,
  input  logic [XLEN-1:0] A_in,
  input  logic [XLEN-1:0] B_in,
  input  logic [5:0]      alu_op_in,
  input  logic            op2_sel_in,
  input  logic [5:0]      shift_amount_in,
  input  logic            is_branch_in,
  input  logic [1:0]      branch_type_in,
  input  logic            is_jump_in,
  input  logic            is_jal_in,
  input  logic            is_jr_in,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] B_fwd_out,
  output logic            redirect_out,
  output logic [31:0]     redirect_pc_out,
  output logic            stall_out,
  output logic            md_busy_out
);

  logic            valid;
  logic            logic_op;
  logic [XLEN-1:0] op2, hi, lo;
  logic [31:0]     pc4, br_target, j_target;
  logic [4:0]      shamt;
  logic            br_taken;
  logic            md_start;
  logic            unused_bits;

  assign valid     = !bubble_in && !rst;
  assign logic_op  = (alu_op_in == OP_AND) || (alu_op_in == OP_OR) || (alu_op_in == OP_XOR);
  assign op2       = op2_sel_in ? (logic_op ? {{(XLEN-16){1'b0}}, ir_in[15:0]}
                                            : {{(XLEN-16){ir_in[15]}}, ir_in[15:0]})
                                : B_in;
  assign shamt     = shift_amount_in[4:0];
  assign pc4       = pc_in + 32'd4;
  assign br_target = pc4 + {{14{ir_in[15]}}, ir_in[15:0], 2'b00};
  assign j_target  = {pc4[31:28], ir_in[25:0], 2'b00};
  assign B_fwd_out = B_in;
  assign unused_bits = ^{ir_in[31:26], shift_amount_in[5]};

  always_comb begin
    br_taken = 1'b0;
    case (branch_type_in)
      BR_BEQ:  br_taken = (A_in == B_in);
      BR_BNE:  br_taken = (A_in != B_in);
      BR_BLEZ: br_taken = ($signed(A_in) <= 0);
      BR_BGTZ: br_taken = ($signed(A_in) > 0);
      default: br_taken = 1'b0;
    endcase
  end

  assign redirect_out    = valid && ((is_branch_in && br_taken) || is_jump_in || is_jr_in);
  assign redirect_pc_out = is_jr_in ? A_in[31:0] : (is_jump_in ? j_target : br_target);

  // Anything touching HI/LO waits while the unit iterates; the interlocked
  // ops are never control flow, so stall and redirect cannot coincide.
  assign stall_out = valid && md_busy_out && is_hilo_op(alu_op_in);
  assign md_start  = valid && !stall_out && is_md_op(alu_op_in);

  always_comb begin
    alu_result_out = '0;
    if (valid) begin
      if (is_jal_in) begin
        alu_result_out = XLEN'(pc4);
      end else begin
        case (alu_op_in)
          OP_ADD:  alu_result_out = A_in + op2;
          OP_SUB:  alu_result_out = A_in - op2;
          OP_AND:  alu_result_out = A_in & op2;
          OP_OR:   alu_result_out = A_in | op2;
          OP_XOR:  alu_result_out = A_in ^ op2;
          OP_NOR:  alu_result_out = ~(A_in | op2);
          OP_SLT:  alu_result_out = {{(XLEN-1){1'b0}}, $signed(A_in) < $signed(op2)};
          OP_SLTU: alu_result_out = {{(XLEN-1){1'b0}}, A_in < op2};
          OP_SLL:  alu_result_out = op2 << shamt;
          OP_SRL:  alu_result_out = op2 >> shamt;
          OP_SRA:  alu_result_out = $signed(op2) >>> shamt;
          OP_LUI:  alu_result_out = {ir_in[15:0], 16'h0000};
          OP_MFHI: alu_result_out = hi;
          OP_MFLO: alu_result_out = lo;
          default: alu_result_out = '0;
        endcase
      end
    end
  end

  ix_muldiv_unit #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .start       (md_start),
    .is_div      (alu_op_in[1]),
    .is_unsigned (alu_op_in[0]),
    .a           (A_in),
    .b           (B_in),
    .hi_we       (valid && !stall_out && alu_op_in == OP_MTHI),
    .lo_we       (valid && !stall_out && alu_op_in == OP_MTLO),
    .wdata       (A_in),
    .hi          (hi),
    .lo          (lo),
    .busy        (md_busy_out)
  );

endmodule

// File: doc/ix_execute_stage.md
Name: ix_execute_stage

Overview:
- Execute (IX) stage; consumes the ID/IX pipeline register outputs and feeds the IX/MEM register.
- Single-cycle ALU and shifter, branch/jump resolution with front-end flush, and an iterative 32-cycle multiply/divide unit with HI/LO registers.
- Raises a stall back to IF/ID while a HI/LO dependency or a second mult/div must wait.

Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iterations per mult/div.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- bubble_in  in  1  ID/IX stall_out; 1 = slot holds no instruction
- pc_in  in  32  instruction PC
- ir_in  in  32  instruction word
- A_in  in  32  source 1 value
- B_in  in  32  source 2 value
- alu_op_in  in  6  operation code (pkg)
- op2_sel_in  in  1  1 = immediate, 0 = B_in
- shift_amount_in  in  6  shift count (low 5 bits used)
- is_branch_in  in  1  conditional branch
- branch_type_in  in  2  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ
- is_jump_in  in  1  J/JAL
- is_jal_in  in  1  link instruction
- is_jr_in  in  1  register jump
- alu_result_out  out  32  result to IX/MEM
- B_fwd_out  out  32  B_in passthrough (store data)
- redirect_out  out  1  taken branch/jump; flushes IF/ID and ID/IX
- redirect_pc_out  out  32  target PC
- stall_out  out  1  hold IF/ID/ID-IX; insert bubble into IX/MEM
- md_busy_out  out  1  mult/div iterating

Behaviour:
- Reset values:
  - HI = LO = 0; counter = 0; state IDLE.
  - redirect_out = 0, stall_out = 0, md_busy_out = 0.
  - Combinational outputs follow from reset state.
- Valid instruction = !bubble_in && !rst. A bubble produces no redirect, no stall and no mult/div issue; alu_result_out = 0.
- Operand 2:
  - op2_sel = 1: zero-extended ir[15:0] for AND/OR/XOR; sign-extended ir[15:0] otherwise.
  - op2_sel = 0: B_in.
- Single-cycle ops are combinational, zero latency.
  - ADD/SUB wrap modulo 2^32; no overflow trap.
  - SLT is signed, SLTU is unsigned; result is 0 or 1.
  - SLL/SRL/SRA shift op2 by shift_amount[4:0].
  - LUI = {ir[15:0], 16'h0}.
- Branch:
  - Condition uses A and B (BLEZ/BGTZ use A signed only).
  - Target = pc+4 + (sext(ir[15:0]) << 2).
- Jump target = {pc+4[31:28], ir[25:0], 2'b00}. JR target = A_in.
- JAL/JALR: alu_result = pc+4 (no delay slot).
- redirect_out = valid && (taken branch || is_jump || is_jr), asserted in the same cycle.
- Mult/div FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: on posedge with a valid MULT/MULTU/DIV/DIVU and stall_out = 0. Operands latched as magnitudes plus sign flags; counter = MD_CYCLES.
  - RUN: one shift-add (mult) or restoring-subtract (div) step per clock; counter decrements.
  - RUN -> DONE: when counter reaches 1.
  - DONE: apply sign correction, write HI/LO, then -> IDLE. Total issue-to-HI/LO = MD_CYCLES+1 clocks.
  - md_busy_out = (state != IDLE).
- Results:
  - MULT: {HI,LO} = 64-bit product.
  - DIV: LO = quotient, HI = remainder; remainder takes the sign of the dividend.
  - Divide by zero: LO = 32'hFFFFFFFF, HI = dividend (both signed and unsigned).
  - Signed 0x80000000 / -1: LO = 0x80000000, HI = 0.
- The issuing mult/div leaves IX in one cycle with alu_result = 0. It does not stall unless an interlock applies.
- Interlock: stall_out = valid && md_busy && op in {MFHI, MFLO, MTHI, MTLO, MULT*, DIV*}. Stalled instruction stays in ID/IX and re-evaluates each cycle. Releases in the cycle after DONE.
- MTHI/MTLO write HI/LO on posedge when valid and not stalled.
- Stall and redirect are never simultaneous: interlocked ops are not control flow.
- Reset mid-RUN aborts the operation, clears HI/LO and returns to IDLE immediately.

Decomposition:
- Package ix_pkg holds:
  - alu_op encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10, LUI 11, MULT 12, MULTU 13, DIV 14, DIVU 15, MFHI 16, MFLO 17, MTHI 18, MTLO 19.
  - branch_type codes.
  - FSM state encoding.
- One sub-module, ix_muldiv_unit: FSM, counter, HI/LO, sign fix-up.
- ALU, branch and stall logic stay in ix_execute_stage.

Test Plan:
- ADD A=0x7FFFFFFF, B=1 -> alu_result 0x80000000, no redirect. SLT A=-1, B=1 -> 1; SLTU same operands -> 0.
- BEQ pc=0x100, A=B=5, imm=0xFFFF -> redirect=1, redirect_pc=0x100. BNE with same operands -> redirect=0. Same BEQ with bubble_in=1 -> redirect=0.
- JAL pc=0x40000010, ir[25:0]=0x10 -> redirect_pc=0x40000040, alu_result=0x40000014. JR A=0x1234 -> redirect_pc=0x1234.
- MULT A=-3, B=7, then MFLO next cycle:
  - stall_out held high for 33 cycles.
  - Then MFLO returns 0xFFFFFFEB; MFHI returns 0xFFFFFFFF.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=9, B=0 -> LO=0xFFFFFFFF, HI=9. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Assert rst at cycle 10 of a DIVU -> md_busy=0, HI=LO=0 immediately; subsequent MFLO not stalled, returns 0.
